// File: rtl/spi_slave_frame_rx.sv
// -----------------------------------------------------------------------------
// spi_slave_frame_rx
// SPI mode-0 slave front end. SCK/CS_n/MOSI are oversampled in the sysClk
// domain, MSB-first bytes are deserialised and numbered within a chip-select
// frame (byte 0 = instruction, 1..N = data), and a response byte is shifted
// out on MISO from a one-deep transmit holding register.
//
// Ports
//   sysClk, rst        : system clock, synchronous active-high reset
//   spi_sck/cs_n/mosi  : asynchronous SPI pins from the host
//   spi_miso           : registered serial data out (0 while CS is high)
//   spi_byte           : last completed received byte
//   spi_input_valid    : one-cycle pulse, spi_byte / spi_byte_num valid
//   spi_byte_num       : index of spi_byte in the frame, saturating
//   frame_active       : a frame is being received
//   frame_error        : one-cycle pulse, CS rose with a partial byte
//   tx_byte/tx_valid   : response byte offer from downstream
//   tx_ready           : holding register empty
//   tx_underrun        : one-cycle pulse, byte boundary with nothing to send
// -----------------------------------------------------------------------------
module spi_slave_frame_rx #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned BYTE_NUM_W   = 4,
  parameter logic [7:0]  IDLE_TX_BYTE = 8'h00
) (
  input  logic                  sysClk,
  input  logic                  rst,
  input  logic                  spi_sck,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic [7:0]            spi_byte,
  output logic                  spi_input_valid,
  output logic [BYTE_NUM_W-1:0] spi_byte_num,
  output logic                  frame_active,
  output logic                  frame_error,
  input  logic [7:0]            tx_byte,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_underrun
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // synchroniser chains; smp_vld marks stages that hold a real pin sample
  logic [SYNC_STAGES-1:0] sck_sync_q,  sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] smp_vld_q,   smp_vld_d;
  logic                   sck_dly_q,   sck_dly_d;
  logic                   cs_dly_q,    cs_dly_d;
  logic                   armed_q,     armed_d;

  state_t                 state_q,     state_d;
  logic [2:0]             bit_cnt_q,   bit_cnt_d;
  logic [BYTE_NUM_W-1:0]  byte_cnt_q,  byte_cnt_d;
  logic [7:0]             shift_in_q,  shift_in_d;
  logic                   done_q,      done_d;
  logic [BYTE_NUM_W-1:0]  done_num_q,  done_num_d;
  logic                   pend_bnd_q,  pend_bnd_d;
  logic [7:0]             hold_q,      hold_d;
  logic                   tx_ready_q,  tx_ready_d;
  logic [7:0]             tx_shift_q,  tx_shift_d;

  logic                   miso_q,         miso_d;
  logic [7:0]             spi_byte_q,     spi_byte_d;
  logic                   valid_q,        valid_d;
  logic [BYTE_NUM_W-1:0]  byte_num_q,     byte_num_d;
  logic                   frame_active_q, frame_active_d;
  logic                   frame_error_q,  frame_error_d;
  logic                   underrun_q,     underrun_d;

  logic sck_s, cs_s, mosi_s, in_shift_s;
  logic sck_rise_s, sck_fall_s, cs_fall_s, cs_rise_s;
  logic bnd_s, accept_s;

  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign cs_s       = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign in_shift_s = (state_q == ST_SHIFT);

  // SCK edges only count inside a frame; this also lets an 8th rise that
  // coincides with CS rising still complete its byte.
  assign sck_rise_s = in_shift_s &  sck_s & ~sck_dly_q;
  assign sck_fall_s = in_shift_s & ~sck_s &  sck_dly_q;
  // armed_q blocks the fake CS fall seen when the preset-high synchroniser
  // drains a CS pin that was already low through a reset.
  assign cs_fall_s  = ~in_shift_s & armed_q & ~cs_s & cs_dly_q;
  assign cs_rise_s  = in_shift_s & cs_s & ~cs_dly_q;

  assign accept_s   = tx_valid & tx_ready_q;

  // Synchroniser shift, delayed copies and arming next-state
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0],  spi_sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   spi_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    smp_vld_d   = {smp_vld_q[SYNC_STAGES-2:0],   1'b1};
    sck_dly_d   = sck_s;
    cs_dly_d    = cs_s;
    armed_d     = armed_q | (cs_s & smp_vld_q[SYNC_STAGES-1]);
  end

  // Frame FSM, deserialiser, MISO shifter and holding register next-state
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    byte_cnt_d     = byte_cnt_q;
    shift_in_d     = shift_in_q;
    done_d         = 1'b0;
    done_num_d     = done_num_q;
    pend_bnd_d     = pend_bnd_q;
    hold_d         = hold_q;
    tx_ready_d     = tx_ready_q;
    tx_shift_d     = tx_shift_q;
    spi_byte_d     = spi_byte_q;
    valid_d        = 1'b0;
    byte_num_d     = byte_num_q;
    frame_error_d  = 1'b0;
    underrun_d     = 1'b0;
    bnd_s          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_d    = ST_SHIFT;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = {BYTE_NUM_W{1'b0}};
          pend_bnd_d = 1'b0;
          bnd_s      = 1'b1;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (sck_rise_s) begin
          shift_in_d = {shift_in_q[6:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            done_d     = 1'b1;
            done_num_d = byte_cnt_q;
            pend_bnd_d = 1'b1;
            if (byte_cnt_q != {BYTE_NUM_W{1'b1}}) begin
              byte_cnt_d = byte_cnt_q + BYTE_NUM_W'(1);
            end else begin
              byte_cnt_d = byte_cnt_q;
            end
          end else begin
            done_d = 1'b0;
          end
        end else begin
          shift_in_d = shift_in_q;
        end
        // the falling edge after a completed byte reloads; others shift
        if (sck_fall_s && !cs_rise_s) begin
          if (pend_bnd_q) begin
            bnd_s      = 1'b1;
            pend_bnd_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end else begin
          bnd_s = 1'b0;
        end
        if (cs_rise_s) begin
          state_d       = ST_IDLE;
          frame_error_d = (bit_cnt_d != 3'd0);
        end else begin
          state_d       = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bnd_s) begin
      if (!tx_ready_q) begin
        tx_shift_d = hold_q;
      end else begin
        tx_shift_d = IDLE_TX_BYTE;
        underrun_d = 1'b1;
      end
    end else begin
      underrun_d = 1'b0;
    end

    // a new accept wins over the boundary's "now empty"
    if (accept_s) begin
      hold_d     = tx_byte;
      tx_ready_d = 1'b0;
    end else if (bnd_s) begin
      tx_ready_d = 1'b1;
    end else begin
      tx_ready_d = tx_ready_q;
    end

    if (done_q) begin
      spi_byte_d = shift_in_q;
      byte_num_d = done_num_q;
      valid_d    = 1'b1;
    end else begin
      valid_d    = 1'b0;
    end

    frame_active_d = (state_d == ST_SHIFT);
    miso_d         = frame_active_d ? tx_shift_d[7] : 1'b0;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge sysClk) begin
    if (rst) begin
      sck_sync_q     <= {SYNC_STAGES{1'b0}};
      cs_sync_q      <= {SYNC_STAGES{1'b1}};
      mosi_sync_q    <= {SYNC_STAGES{1'b0}};
      smp_vld_q      <= {SYNC_STAGES{1'b0}};
      sck_dly_q      <= 1'b0;
      cs_dly_q       <= 1'b1;
      armed_q        <= 1'b0;
      state_q        <= ST_IDLE;
      bit_cnt_q      <= 3'd0;
      byte_cnt_q     <= {BYTE_NUM_W{1'b0}};
      shift_in_q     <= 8'h00;
      done_q         <= 1'b0;
      done_num_q     <= {BYTE_NUM_W{1'b0}};
      pend_bnd_q     <= 1'b0;
      hold_q         <= 8'h00;
      tx_ready_q     <= 1'b1;
      tx_shift_q     <= IDLE_TX_BYTE;
      miso_q         <= 1'b0;
      spi_byte_q     <= 8'h00;
      valid_q        <= 1'b0;
      byte_num_q     <= {BYTE_NUM_W{1'b0}};
      frame_active_q <= 1'b0;
      frame_error_q  <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      sck_sync_q     <= sck_sync_d;
      cs_sync_q      <= cs_sync_d;
      mosi_sync_q    <= mosi_sync_d;
      smp_vld_q      <= smp_vld_d;
      sck_dly_q      <= sck_dly_d;
      cs_dly_q       <= cs_dly_d;
      armed_q        <= armed_d;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      byte_cnt_q     <= byte_cnt_d;
      shift_in_q     <= shift_in_d;
      done_q         <= done_d;
      done_num_q     <= done_num_d;
      pend_bnd_q     <= pend_bnd_d;
      hold_q         <= hold_d;
      tx_ready_q     <= tx_ready_d;
      tx_shift_q     <= tx_shift_d;
      miso_q         <= miso_d;
      spi_byte_q     <= spi_byte_d;
      valid_q        <= valid_d;
      byte_num_q     <= byte_num_d;
      frame_active_q <= frame_active_d;
      frame_error_q  <= frame_error_d;
      underrun_q     <= underrun_d;
    end
  end

  assign spi_miso        = miso_q;
  assign spi_byte        = spi_byte_q;
  assign spi_input_valid = valid_q;
  assign spi_byte_num    = byte_num_q;
  assign frame_active    = frame_active_q;
  assign frame_error     = frame_error_q;
  assign tx_ready        = tx_ready_q;
  assign tx_underrun     = underrun_q;

endmodule

// File: tb/tb_spi_slave_frame_rx.sv
// -----------------------------------------------------------------------------
// Bench for spi_slave_frame_rx: a host SPI model drives frames of random and
// fixed bytes; expected bytes, indices, latencies and MISO bytes are derived
// from the frame contents and the holding-register rules.
// -----------------------------------------------------------------------------
module tb_spi_slave_frame_rx;

  localparam int S    = 2;
  localparam int BNW  = 4;
  localparam int HALF = 4;      // sysClk cycles per SCK phase
  localparam int LAT  = S + 2;  // pin 8th SCK rise to spi_input_valid

  logic           sysClk = 1'b0;
  logic           rst, spi_sck, spi_cs_n, spi_mosi, spi_miso;
  logic [7:0]     spi_byte, tx_byte;
  logic           spi_input_valid, frame_active, frame_error;
  logic [BNW-1:0] spi_byte_num;
  logic           tx_valid, tx_ready, tx_underrun;

  spi_slave_frame_rx #(.SYNC_STAGES(S), .BYTE_NUM_W(BNW), .IDLE_TX_BYTE(8'h00)) dut (
    .sysClk(sysClk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_byte(spi_byte),
    .spi_input_valid(spi_input_valid), .spi_byte_num(spi_byte_num),
    .frame_active(frame_active), .frame_error(frame_error),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_underrun(tx_underrun)
  );

  always #5 sysClk = ~sysClk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge sysClk) cyc <= cyc + 1;

  // observed valid pulses and pulse counters
  logic [7:0] obs_byte [0:255];
  int         obs_num  [0:255];
  int         obs_cyc  [0:255];
  int         obs_n  = 0;
  int         ferr_n = 0;
  int         und_n  = 0;

  always @(negedge sysClk) begin
    if (spi_input_valid && obs_n < 256) begin
      obs_byte[obs_n] <= spi_byte;
      obs_num[obs_n]  <= int'(spi_byte_num);
      obs_cyc[obs_n]  <= cyc;
      obs_n           <= obs_n + 1;
    end
    if (frame_error) ferr_n <= ferr_n + 1;
    if (tx_underrun) und_n  <= und_n + 1;
  end

  // host-side frame data and the expectations derived from it
  logic [7:0] frame_data [0:31];
  logic [7:0] frame_miso [0:31];
  logic [7:0] exp_byte   [0:31];
  int         exp_num    [0:31];
  int         exp_cyc    [0:31];

  task automatic clk_n(input int n);
    repeat (n) @(negedge sysClk);
  endtask

  // mode 0: data set while SCK low, sampled by both sides on the rise
  task automatic shift_bits(input logic [7:0] b, input int nbits,
                            output logic [7:0] miso_b, output int rise_cyc);
    miso_b   = 8'h00;
    rise_cyc = 0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi  = b[i];
      clk_n(HALF);
      spi_sck   = 1'b1;
      miso_b[i] = spi_miso;
      rise_cyc  = cyc;
      clk_n(HALF);
      spi_sck   = 1'b0;
    end
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    clk_n(6);
  endtask

  // SCK has already returned low; CS rises one phase later
  task automatic cs_end();
    clk_n(HALF);
    spi_cs_n = 1'b1;
    clk_n(10);
  endtask

  task automatic send_frame(input int n);
    int rc;
    cs_begin();
    for (int k = 0; k < n; k++) begin
      shift_bits(frame_data[k], 8, frame_miso[k], rc);
      exp_byte[k] = frame_data[k];
      exp_num[k]  = (k > 15) ? 15 : k;
      exp_cyc[k]  = rc + LAT;
    end
    cs_end();
  endtask

  task automatic offer_tx(input logic [7:0] b);
    int waited = 0;
    while (tx_ready !== 1'b1 && waited < 64) begin
      clk_n(1);
      waited++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL tx_ready_wait: tx_ready=%b, required 1 within 64 cycles", tx_ready);
    end
    tx_byte  = b;
    tx_valid = 1'b1;
    clk_n(1);
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    tx_valid = 1'b0; tx_byte = 8'h00;
    clk_n(3);
    rst = 1'b0;
    clk_n(1);
    checks++;
    if ({spi_miso, spi_input_valid, frame_active, frame_error, tx_underrun} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags: miso/valid/active/err/und=%b%b%b%b%b, required 00000",
               spi_miso, spi_input_valid, frame_active, frame_error, tx_underrun);
    end
    checks++;
    if (spi_byte !== 8'h00 || spi_byte_num !== 4'd0) begin
      errors++;
      $display("FAIL reset_byte: byte=%h num=%0d, required 00 / 0", spi_byte, spi_byte_num);
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx_ready: tx_ready=%b, required 1", tx_ready);
    end
  endtask

  task automatic test_basic_frame();
    int o0 = obs_n;
    int f0 = ferr_n;
    int got;
    frame_data[0] = 8'hA5;
    for (int k = 1; k < 9; k++) frame_data[k] = 8'(k);
    send_frame(9);
    got = obs_n - o0;
    checks++;
    if (got !== 9) begin
      errors++;
      $display("FAIL basic_count: valid pulses=%0d, required 9", got);
    end
    for (int k = 0; k < 9 && k < got; k++) begin
      checks++;
      if (obs_byte[o0+k] !== exp_byte[k]) begin
        errors++;
        $display("FAIL basic_byte[%0d]: got %h, required %h", k, obs_byte[o0+k], exp_byte[k]);
      end
      checks++;
      if (obs_num[o0+k] !== exp_num[k]) begin
        errors++;
        $display("FAIL basic_num[%0d]: got %0d, required %0d", k, obs_num[o0+k], exp_num[k]);
      end
      checks++;
      if (obs_cyc[o0+k] !== exp_cyc[k]) begin
        errors++;
        $display("FAIL basic_latency[%0d]: valid at cycle %0d, required %0d", k, obs_cyc[o0+k], exp_cyc[k]);
      end
    end
    checks++;
    if (ferr_n - f0 !== 0) begin
      errors++;
      $display("FAIL basic_frame_error: pulses=%0d, required 0", ferr_n - f0);
    end
  endtask

  task automatic test_abort();
    logic [7:0] m;
    int rc;
    int o0 = obs_n;
    int f0 = ferr_n;
    cs_begin();
    checks++;
    if (frame_active !== 1'b1) begin
      errors++;
      $display("FAIL abort_active: frame_active=%b, required 1", frame_active);
    end
    shift_bits(8'($urandom_range(0, 255)), 5, m, rc);
    cs_end();
    checks++;
    if (frame_active !== 1'b0) begin
      errors++;
      $display("FAIL abort_inactive: frame_active=%b, required 0", frame_active);
    end
    checks++;
    if (ferr_n - f0 !== 1) begin
      errors++;
      $display("FAIL abort_frame_error: pulses=%0d, required 1", ferr_n - f0);
    end
    checks++;
    if (obs_n - o0 !== 0) begin
      errors++;
      $display("FAIL abort_no_valid: valid pulses=%0d, required 0", obs_n - o0);
    end
    o0 = obs_n;
    frame_data[0] = 8'($urandom_range(0, 255));
    send_frame(1);
    checks++;
    if (obs_n - o0 !== 1 || obs_num[o0] !== 0 || obs_byte[o0] !== frame_data[0]) begin
      errors++;
      $display("FAIL abort_next_frame: pulses=%0d byte=%h num=%0d, required 1 / %h / 0",
               obs_n - o0, obs_byte[o0], obs_num[o0], frame_data[0]);
    end
    checks++;
    if (ferr_n - f0 !== 1) begin
      errors++;
      $display("FAIL abort_next_error: pulses=%0d, required 1", ferr_n - f0);
    end
  endtask

  task automatic test_tx_path();
    logic [7:0] m0, m1, nxt;
    int rc;
    int u0 = und_n;
    nxt = 8'($urandom_range(0, 255));
    offer_tx(8'h3C);
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL tx_held: tx_ready=%b, required 0", tx_ready);
    end
    cs_begin();
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL tx_ready_after_load: tx_ready=%b, required 1", tx_ready);
    end
    offer_tx(8'hC3);
    shift_bits(8'($urandom_range(0, 255)), 8, m0, rc);
    offer_tx(nxt);  // keeps the last boundary from underrunning
    shift_bits(8'($urandom_range(0, 255)), 8, m1, rc);
    cs_end();
    checks++;
    if (m0 !== 8'h3C) begin
      errors++;
      $display("FAIL tx_miso_byte0: got %h, required 3c", m0);
    end
    checks++;
    if (m1 !== 8'hC3) begin
      errors++;
      $display("FAIL tx_miso_byte1: got %h, required c3", m1);
    end
    checks++;
    if (und_n - u0 !== 0) begin
      errors++;
      $display("FAIL tx_no_underrun: pulses=%0d, required 0", und_n - u0);
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL tx_ready_final: tx_ready=%b, required 1", tx_ready);
    end
  endtask

  // boundaries: CS fall plus the SCK fall after each of the 3 bytes
  task automatic test_underrun();
    int u0 = und_n;
    for (int k = 0; k < 3; k++) frame_data[k] = 8'($urandom_range(0, 255));
    send_frame(3);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (frame_miso[k] !== 8'h00) begin
        errors++;
        $display("FAIL underrun_miso[%0d]: got %h, required 00", k, frame_miso[k]);
      end
    end
    checks++;
    if (und_n - u0 !== 4) begin
      errors++;
      $display("FAIL underrun_count: pulses=%0d, required 4", und_n - u0);
    end
  endtask

  task automatic test_saturation();
    int o0 = obs_n;
    int got;
    for (int k = 0; k < 17; k++) frame_data[k] = 8'($urandom_range(0, 255));
    send_frame(17);
    got = obs_n - o0;
    checks++;
    if (got !== 17) begin
      errors++;
      $display("FAIL sat_count: valid pulses=%0d, required 17", got);
    end
    for (int k = 0; k < 17 && k < got; k++) begin
      checks++;
      if (obs_num[o0+k] !== exp_num[k] || obs_byte[o0+k] !== exp_byte[k]) begin
        errors++;
        $display("FAIL sat_byte[%0d]: got %h/%0d, required %h/%0d",
                 k, obs_byte[o0+k], obs_num[o0+k], exp_byte[k], exp_num[k]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] m;
    int rc;
    int o0;
    cs_begin();
    for (int k = 0; k < 3; k++) begin
      frame_data[k] = 8'($urandom_range(0, 255)) | 8'h80;
      shift_bits(frame_data[k], 8, m, rc);
    end
    rst = 1'b1;
    clk_n(2);
    rst = 1'b0;
    clk_n(1);
    checks++;
    if ({spi_miso, spi_input_valid, frame_active, frame_error, tx_underrun, tx_ready} !== 6'b000001
        || spi_byte !== 8'h00 || spi_byte_num !== 4'd0) begin
      errors++;
      $display("FAIL midrst_outputs: miso/valid/act/err/und/rdy=%b%b%b%b%b%b byte=%h num=%0d, required 000001 00 0",
               spi_miso, spi_input_valid, frame_active, frame_error, tx_underrun, tx_ready,
               spi_byte, spi_byte_num);
    end
    o0 = obs_n;
    clk_n(8);
    shift_bits(8'($urandom_range(0, 255)), 8, m, rc);
    clk_n(8);
    checks++;
    if (obs_n - o0 !== 0 || frame_active !== 1'b0 || m !== 8'h00) begin
      errors++;
      $display("FAIL midrst_ignored: valid pulses=%0d active=%b miso=%h, required 0 / 0 / 00",
               obs_n - o0, frame_active, m);
    end
    cs_end();
    o0 = obs_n;
    frame_data[0] = 8'($urandom_range(0, 255));
    send_frame(1);
    checks++;
    if (obs_n - o0 !== 1 || obs_num[o0] !== 0 || obs_byte[o0] !== frame_data[0]) begin
      errors++;
      $display("FAIL midrst_recover: pulses=%0d byte=%h num=%0d, required 1 / %h / 0",
               obs_n - o0, obs_byte[o0], obs_num[o0], frame_data[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_abort();
    test_tx_path();
    test_underrun();
    test_saturation();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running at time %0t, required completion", $time);
    $fatal(1);
  end

endmodule
